// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings between the control unit and the CPU datapath:
// opcodes, FSM states, bus source select and ALU operation.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_SHR  = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_DIV  = 5'b01010;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    typedef enum logic [3:0] {
        IDLE, F0, F1, F2, T3, T4, T5, T6, T7, MWAIT, MD, HALT
    } state_e;

    typedef enum logic [3:0] {
        BUS_NONE = 4'd0, BUS_GPR = 4'd1, BUS_PC = 4'd2, BUS_MDR = 4'd3, BUS_ZLO = 4'd4,
        BUS_ZHI  = 4'd5, BUS_HI  = 4'd6, BUS_LO = 4'd7, BUS_IMM = 4'd8
    } bus_src_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_SHR = 4'd4,
        ALU_SHL = 4'd5, ALU_MUL = 4'd6, ALU_DIV = 4'd7, ALU_INC4 = 4'd8
    } alu_op_e;

endpackage

// File: rtl/control_unit_if.sv
// Signal bundle between the control unit (master) and the datapath/memory side (slave).
interface control_unit_if;
    logic        run;
    logic [31:0] ir;
    logic        mem_rdy;
    logic [3:0]  bus_src;
    logic [3:0]  gpr_sel;
    logic [3:0]  alu_op;
    logic        gpr_in, pc_in, pc_inc, ir_in, mar_in, mdr_in, mdr_from_mem;
    logic        y_in, z_in, hi_in, lo_in, mem_rd, mem_wr, halted, illegal;

    modport master (
        input  run, ir, mem_rdy,
        output bus_src, gpr_sel, alu_op, gpr_in, pc_in, pc_inc, ir_in, mar_in, mdr_in,
               mdr_from_mem, y_in, z_in, hi_in, lo_in, mem_rd, mem_wr, halted, illegal
    );

    modport slave (
        output run, ir, mem_rdy,
        input  bus_src, gpr_sel, alu_op, gpr_in, pc_in, pc_inc, ir_in, mar_in, mdr_in,
               mdr_from_mem, y_in, z_in, hi_in, lo_in, mem_rd, mem_wr, halted, illegal
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle fetch/execute sequencer driving the CPU datapath strobes.
// One flat FSM; a single counter times both mul/div latency and memory waits.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int WAIT_MAX      = 15
) (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master cu
);
    localparam int CNT_TOP = (MULDIV_CYCLES > WAIT_MAX) ? MULDIV_CYCLES : WAIT_MAX;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);
    localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(WAIT_MAX);

    state_e           r_state, w_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       w_op;
    logic [3:0]       w_ra, w_rb, w_rc;
    logic             w_rtype, w_ld, w_st, w_imm, w_md;
    alu_op_e          w_alu;

    assign w_op    = cu.ir[31:27];
    assign w_ra    = cu.ir[26:23];
    assign w_rb    = cu.ir[22:19];
    assign w_rc    = cu.ir[18:15];
    assign w_rtype = (w_op >= OP_ADD) && (w_op <= OP_SHL);
    assign w_ld    = (w_op == OP_LD);
    assign w_st    = (w_op == OP_ST);
    assign w_imm   = w_ld || w_st || (w_op == OP_ADDI);
    assign w_md    = (w_op == OP_MUL) || (w_op == OP_DIV);

    always_comb begin
        case (w_op)
            OP_SUB:  w_alu = ALU_SUB;
            OP_AND:  w_alu = ALU_AND;
            OP_OR:   w_alu = ALU_OR;
            OP_SHR:  w_alu = ALU_SHR;
            OP_SHL:  w_alu = ALU_SHL;
            OP_MUL:  w_alu = ALU_MUL;
            OP_DIV:  w_alu = ALU_DIV;
            default: w_alu = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            // counter runs only while parked in MD/MWAIT; any state change rearms it
            if (w_nxt == r_state && (r_state == MD || r_state == MWAIT))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_nxt           = r_state;
        cu.bus_src      = BUS_NONE;
        cu.gpr_sel      = '0;
        cu.alu_op       = ALU_ADD;
        cu.gpr_in       = 1'b0;
        cu.pc_in        = 1'b0;
        cu.pc_inc       = 1'b0;
        cu.ir_in        = 1'b0;
        cu.mar_in       = 1'b0;
        cu.mdr_in       = 1'b0;
        cu.mdr_from_mem = 1'b0;
        cu.y_in         = 1'b0;
        cu.z_in         = 1'b0;
        cu.hi_in        = 1'b0;
        cu.lo_in        = 1'b0;
        cu.mem_rd       = 1'b0;
        cu.mem_wr       = 1'b0;
        cu.halted       = 1'b0;
        cu.illegal      = 1'b0;
        unique case (r_state)
            IDLE: if (cu.run) w_nxt = F0;
            F0: begin
                cu.bus_src = BUS_PC;
                cu.mar_in  = 1'b1;
                cu.pc_inc  = 1'b1;
                w_nxt      = F1;
            end
            F1: begin
                cu.mem_rd       = 1'b1;
                cu.mdr_from_mem = 1'b1;
                cu.mdr_in       = 1'b1;
                if (cu.mem_rdy) w_nxt = F2;
            end
            F2: begin
                cu.bus_src = BUS_MDR;
                cu.ir_in   = 1'b1;
                w_nxt      = T3;
            end
            T3: begin
                if (w_rtype || w_imm || w_md) begin
                    cu.bus_src = BUS_GPR;
                    cu.gpr_sel = w_rb;
                    cu.y_in    = 1'b1;
                    w_nxt      = T4;
                end else if (w_op == OP_NOP) begin
                    w_nxt = IDLE;
                end else if (w_op == OP_HALT) begin
                    w_nxt = HALT;
                end else begin
                    cu.illegal = 1'b1;
                    w_nxt      = IDLE;
                end
            end
            T4: begin
                cu.bus_src = w_imm ? BUS_IMM : BUS_GPR;
                cu.gpr_sel = w_imm ? 4'd0 : w_rc;
                cu.alu_op  = w_alu;
                cu.z_in    = 1'b1;
                w_nxt      = w_md ? MD : T5;
            end
            MD: if (r_cnt == MD_LAST) w_nxt = T5;
            T5: begin
                cu.bus_src = BUS_ZLO;
                if (w_md) begin
                    cu.lo_in = 1'b1;
                    w_nxt    = T6;
                end else if (w_ld || w_st) begin
                    cu.mar_in = 1'b1;
                    w_nxt     = w_st ? T6 : MWAIT;
                end else begin
                    cu.gpr_sel = w_ra;
                    cu.gpr_in  = 1'b1;
                    w_nxt      = IDLE;
                end
            end
            T6: begin
                if (w_md) begin
                    cu.bus_src = BUS_ZHI;
                    cu.hi_in   = 1'b1;
                    w_nxt      = IDLE;
                end else begin
                    cu.bus_src = BUS_GPR;
                    cu.gpr_sel = w_ra;
                    cu.mdr_in  = 1'b1;
                    w_nxt      = MWAIT;
                end
            end
            MWAIT: begin
                if (w_st) begin
                    cu.mem_wr = 1'b1;
                end else begin
                    cu.mem_rd       = 1'b1;
                    cu.mdr_from_mem = 1'b1;
                    cu.mdr_in       = 1'b1;
                end
                // a completion on the final count still wins over the timeout
                if (cu.mem_rdy) begin
                    w_nxt = w_st ? IDLE : T7;
                end else if (r_cnt == W_LAST) begin
                    cu.illegal = 1'b1;
                    w_nxt      = IDLE;
                end
            end
            T7: begin
                cu.bus_src = BUS_MDR;
                cu.gpr_sel = w_ra;
                cu.gpr_in  = 1'b1;
                w_nxt      = IDLE;
            end
            HALT: cu.halted = 1'b1;
            default: w_nxt = IDLE;
        endcase
    end
endmodule
